// File: rtl/cci_mpf_prim_lru_sched_if.sv
// Scheduler-to-table link: one lookup port with a fixed-latency response and two reference-update ports.
interface cci_mpf_prim_lru_sched_if #(
  parameter int N_WAYS   = 4,
  parameter int IDX_BITS = 10
);
  logic                      lruRdy;
  logic [IDX_BITS-1:0]       lruLookupIdx;
  logic                      lruLookupEn;
  logic [$clog2(N_WAYS)-1:0] lruLookupRsp;
  logic [N_WAYS-1:0]         lruLookupVecRsp;
  logic                      lruLookupRspRdy;
  logic [IDX_BITS-1:0]       lruRefIdx0;
  logic [IDX_BITS-1:0]       lruRefIdx1;
  logic [N_WAYS-1:0]         lruRefWayVec0;
  logic [N_WAYS-1:0]         lruRefWayVec1;
  logic                      lruRefEn0;
  logic                      lruRefEn1;

  modport master (
    input  lruRdy, lruLookupRsp, lruLookupVecRsp, lruLookupRspRdy,
    output lruLookupIdx, lruLookupEn,
    output lruRefIdx0, lruRefIdx1, lruRefWayVec0, lruRefWayVec1, lruRefEn0, lruRefEn1
  );

  modport slave (
    output lruRdy, lruLookupRsp, lruLookupVecRsp, lruLookupRspRdy,
    input  lruLookupIdx, lruLookupEn,
    input  lruRefIdx0, lruRefIdx1, lruRefWayVec0, lruRefWayVec1, lruRefEn0, lruRefEn1
  );
endinterface

// File: rtl/cci_mpf_prim_lru_sched.sv
// Shares the pseudo-LRU table's lookup port and two update ports among N_REQ clients:
// round-robin lookups tagged through the table latency, and a coalescing reference FIFO.
module cci_mpf_prim_lru_sched #(
  parameter  int N_REQ          = 4,
  parameter  int N_WAYS         = 4,
  parameter  int N_ENTRIES      = 1024,
  parameter  int LOOKUP_LATENCY = 3,
  parameter  int REF_FIFO_DEPTH = 8,
  localparam int IDX_BITS       = $clog2(N_ENTRIES),
  localparam int WAY_W          = $clog2(N_WAYS),
  localparam int ID_W           = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       rdy,
  cci_mpf_prim_lru_sched_if.master   lru,
  input  logic [N_REQ-1:0]           reqLookupEn,
  input  logic [N_REQ*IDX_BITS-1:0]  reqLookupIdx,
  output logic [N_REQ-1:0]           reqLookupGnt,
  output logic [N_REQ-1:0]           rspValid,
  output logic [WAY_W-1:0]           rspWay,
  output logic [N_WAYS-1:0]          rspWayVec,
  input  logic [N_REQ-1:0]           reqRefEn,
  input  logic [N_REQ*IDX_BITS-1:0]  reqRefIdx,
  input  logic [N_REQ*N_WAYS-1:0]    reqRefWayVec,
  output logic [N_REQ-1:0]           reqRefGnt,
  output logic [15:0]                dropCnt,
  output logic                       tagErr
);
  localparam int PTR_W = $clog2(REF_FIFO_DEPTH);
  localparam int L     = LOOKUP_LATENCY;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state;
  logic   run;
  logic   ref_open;

  assign run = (state == S_RUN);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  function automatic void rr_pick(input  logic [N_REQ-1:0] req,
                                  input  logic [ID_W-1:0]  ptr,
                                  output logic             found,
                                  output logic [ID_W-1:0]  win);
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (int'(ptr) + k) % N_REQ;
      if (!found && req[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  endfunction

  // The table may drop lruRdy after coming up; references keep being accepted and
  // simply wait in the buffer until the drain resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_INIT;
      rdy      <= 1'b0;
      ref_open <= 1'b0;
    end else begin
      case (state)
        S_INIT: if (lru.lruRdy) begin
          state    <= S_RUN;
          rdy      <= 1'b1;
          ref_open <= 1'b1;
        end
        S_RUN: if (!lru.lruRdy) begin
          state <= S_INIT;
          rdy   <= 1'b0;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  logic            lk_vld;
  logic [ID_W-1:0] lk_win;
  logic [ID_W-1:0] lk_ptr;

  always_comb begin
    rr_pick(reqLookupEn & {N_REQ{run}}, lk_ptr, lk_vld, lk_win);
  end

  assign reqLookupGnt     = lk_vld ? (N_REQ'(1) << lk_win) : '0;
  assign lru.lruLookupEn  = lk_vld;
  assign lru.lruLookupIdx = lk_vld ? reqLookupIdx[lk_win*IDX_BITS +: IDX_BITS] : '0;

  // Stage p0..p(L-1): tag pipe tracking each grant until the table answers
  logic [L-1:0]    tag_vld_p;
  logic [ID_W-1:0] tag_id_p [L];
  logic            tag_hit;

  assign tag_hit = lru.lruLookupRspRdy && tag_vld_p[L-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld_p <= '0;
      rspValid  <= '0;
      rspWay    <= '0;
      rspWayVec <= '0;
      tagErr    <= 1'b0;
    end else begin
      tag_vld_p[0] <= lk_vld;
      for (int s = 1; s < L; s++) tag_vld_p[s] <= tag_vld_p[s-1];
      // Response stage: one cycle after the table's response strobe
      rspValid <= tag_hit ? (N_REQ'(1) << tag_id_p[L-1]) : '0;
      if (tag_hit) begin
        rspWay    <= lru.lruLookupRsp;
        rspWayVec <= lru.lruLookupVecRsp;
      end
      if (lru.lruLookupRspRdy != tag_vld_p[L-1]) tagErr <= 1'b1;
    end
  end

  logic [IDX_BITS-1:0] fifo_idx [REF_FIFO_DEPTH];
  logic [N_WAYS-1:0]   fifo_vec [REF_FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr, occ, occ_after;
  logic [PTR_W-1:0]    head, second, newest;
  logic                en0, en1;
  logic [1:0]          deq;

  assign occ       = wr_ptr - rd_ptr;
  assign head      = rd_ptr[PTR_W-1:0];
  assign second    = head + PTR_W'(1);
  assign newest    = wr_ptr[PTR_W-1:0] - PTR_W'(1);
  // Port 1 shares the table's lookup read port and must not update the same set twice
  assign en0       = run && (occ != '0);
  assign en1       = run && (occ >= (PTR_W+1)'(2)) && !lk_vld && (fifo_idx[second] != fifo_idx[head]);
  assign deq       = {1'b0, en0} + {1'b0, en1};
  assign occ_after = occ - (PTR_W+1)'(deq);

  assign lru.lruRefEn0     = en0;
  assign lru.lruRefIdx0    = en0 ? fifo_idx[head] : '0;
  assign lru.lruRefWayVec0 = en0 ? fifo_vec[head] : '0;
  assign lru.lruRefEn1     = en1;
  assign lru.lruRefIdx1    = en1 ? fifo_idx[second] : '0;
  assign lru.lruRefWayVec1 = en1 ? fifo_vec[second] : '0;

  logic                rf_vld;
  logic [ID_W-1:0]     rf_win;
  logic [ID_W-1:0]     rf_ptr;
  logic [IDX_BITS-1:0] rf_idx;
  logic [N_WAYS-1:0]   rf_vec;
  logic                coalesce, alloc, drop;

  always_comb begin
    rr_pick(reqRefEn & {N_REQ{ref_open}}, rf_ptr, rf_vld, rf_win);
  end

  assign rf_idx    = reqRefIdx[rf_win*IDX_BITS +: IDX_BITS];
  assign rf_vec    = reqRefWayVec[rf_win*N_WAYS +: N_WAYS];
  assign reqRefGnt = rf_vld ? (N_REQ'(1) << rf_win) : '0;
  // Merge only into an entry that survives this cycle's drain
  assign coalesce  = rf_vld && (occ > (PTR_W+1)'(deq)) && (fifo_idx[newest] == rf_idx);
  assign alloc     = rf_vld && !coalesce && (occ_after < (PTR_W+1)'(REF_FIFO_DEPTH));
  assign drop      = rf_vld && !coalesce && !alloc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lk_ptr  <= '0;
      rf_ptr  <= '0;
      dropCnt <= '0;
    end else begin
      rd_ptr <= rd_ptr + (PTR_W+1)'(deq);
      if (alloc)  wr_ptr  <= wr_ptr + (PTR_W+1)'(1);
      if (drop)   dropCnt <= sat_inc16(dropCnt);
      if (lk_vld) lk_ptr  <= next_id(lk_win);
      if (rf_vld) rf_ptr  <= next_id(rf_win);
    end
  end

  always_ff @(posedge clk) begin
    tag_id_p[0] <= lk_win;
    for (int s = 1; s < L; s++) tag_id_p[s] <= tag_id_p[s-1];
    if (alloc) begin
      fifo_idx[wr_ptr[PTR_W-1:0]] <= rf_idx;
      fifo_vec[wr_ptr[PTR_W-1:0]] <= rf_vec;
    end
    if (coalesce) fifo_vec[newest] <= fifo_vec[newest] | rf_vec;
  end
endmodule
